ghost_direction_scheduler: RTL

Per-frame sequencer for the four ghost direction registers. It latches direction requests written by the NIOS, then on each frame tick walks ghosts 0..3 in order. For each ghost it queries the shared maze wall-check port with a req/ack handshake and commits only legal directions. It drives the committed 4x3-bit direction array to the ghost movers and a packed 16-bit status word back to the NIOS.

---
 rtl/ghost_direction_scheduler_if.sv | 31 +++
 rtl/ghost_direction_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ghost_direction_scheduler_if.sv
// Scheduler-facing bundle: NIOS request/status, frame tick, maze wall-check handshake and ghost mover outputs.
interface ghost_direction_scheduler_if #(
  parameter int OVR_CNT_W = 8
);
  logic                 frame_tick;
  logic                 nios_dir_we;
  logic [15:0]          nios_dir_word;
  logic                 query_req;
  logic [1:0]           query_ghost;
  logic [2:0]           query_dir;
  logic                 query_ack;
  logic                 query_legal;
  logic [3:0][2:0]      ghost_dir_fpga;
  logic [15:0]          ghost_dir_status;
  logic                 busy;
  logic                 done;
  logic                 timeout_flag;
  logic [OVR_CNT_W-1:0] overrun_cnt;

  modport master (
    output frame_tick, nios_dir_we, nios_dir_word, query_ack, query_legal,
    input  query_req, query_ghost, query_dir, ghost_dir_fpga, ghost_dir_status,
           busy, done, timeout_flag, overrun_cnt
  );

  modport slave (
    input  frame_tick, nios_dir_we, nios_dir_word, query_ack, query_legal,
    output query_req, query_ghost, query_dir, ghost_dir_fpga, ghost_dir_status,
           busy, done, timeout_flag, overrun_cnt
  );
endinterface

// File: rtl/ghost_direction_scheduler.sv
// Per-frame ghost direction sequencer: checks each requested direction with the maze and commits legal ones.
// Two cycles per ghost with an immediate ack; query_req is held until ack or QUERY_TIMEOUT; all outputs registered.
module ghost_direction_scheduler #(
  parameter int QUERY_TIMEOUT = 16,
  parameter int OVR_CNT_W     = 8
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  ghost_direction_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUERY,
    S_COMMIT,
    S_DONE
  } state_t;

  localparam logic [7:0]           TMO_LAST = 8'(QUERY_TIMEOUT - 1);
  localparam logic [OVR_CNT_W-1:0] OVR_MAX  = {OVR_CNT_W{1'b1}};
  localparam logic [OVR_CNT_W-1:0] OVR_ONE  = {{(OVR_CNT_W-1){1'b0}}, 1'b1};

  state_t               r_state, w_state_nxt;
  logic [3:0][2:0]      r_pending;
  logic [3:0][2:0]      r_snap, w_snap_nxt;
  logic [3:0][2:0]      r_dirs, w_dirs_nxt;
  logic [1:0]           r_idx, w_idx_nxt;
  logic                 r_legal, w_legal_nxt;
  logic [7:0]           r_tmo_cnt, w_tmo_nxt;
  logic                 r_req, w_req_nxt;
  logic [1:0]           r_qghost, w_qghost_nxt;
  logic [2:0]           r_qdir, w_qdir_nxt;
  logic [15:0]          r_status, w_status_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_tflag, w_tflag_nxt;
  logic [OVR_CNT_W-1:0] r_ovr, w_ovr_nxt;

  logic                 w_launch;
  logic [1:0]           w_launch_idx;
  logic [2:0]           w_launch_dir;
  logic [1:0]           w_idx_inc;
  logic [2:0]           w_cur_dir;
  logic                 w_unused_bits;

  // Only directions 1..4 need the wall check; stop is always legal, 5..7 never.
  function automatic logic needs_query(input logic [2:0] d);
    return (d != 3'd0) && (d <= 3'd4);
  endfunction

  assign w_idx_inc     = r_idx + 2'd1;
  assign w_cur_dir     = r_snap[r_idx];
  assign w_unused_bits = ^{bus.nios_dir_word[15], bus.nios_dir_word[11],
                           bus.nios_dir_word[7], bus.nios_dir_word[3]};

  // Pending word is independent of the FSM so NIOS writes never disturb a pass.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pending <= '0;
    end else if (bus.nios_dir_we) begin
      r_pending <= {bus.nios_dir_word[14:12], bus.nios_dir_word[10:8],
                    bus.nios_dir_word[6:4], bus.nios_dir_word[2:0]};
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_snap    <= '0;
      r_dirs    <= '0;
      r_idx     <= 2'd0;
      r_legal   <= 1'b0;
      r_tmo_cnt <= 8'd0;
      r_req     <= 1'b0;
      r_qghost  <= 2'd0;
      r_qdir    <= 3'd0;
      r_status  <= 16'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tflag   <= 1'b0;
      r_ovr     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_snap    <= w_snap_nxt;
      r_dirs    <= w_dirs_nxt;
      r_idx     <= w_idx_nxt;
      r_legal   <= w_legal_nxt;
      r_tmo_cnt <= w_tmo_nxt;
      r_req     <= w_req_nxt;
      r_qghost  <= w_qghost_nxt;
      r_qdir    <= w_qdir_nxt;
      r_status  <= w_status_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_tflag   <= w_tflag_nxt;
      r_ovr     <= w_ovr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_snap_nxt   = r_snap;
    w_dirs_nxt   = r_dirs;
    w_idx_nxt    = r_idx;
    w_legal_nxt  = r_legal;
    w_tmo_nxt    = r_tmo_cnt;
    w_req_nxt    = r_req;
    w_qghost_nxt = r_qghost;
    w_qdir_nxt   = r_qdir;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_tflag_nxt  = r_tflag;
    w_ovr_nxt    = r_ovr;
    w_launch     = 1'b0;
    w_launch_idx = 2'd0;
    w_launch_dir = 3'd0;

    if (bus.frame_tick && (r_state != S_IDLE) && (r_ovr != OVR_MAX)) begin
      w_ovr_nxt = r_ovr + OVR_ONE;
    end

    unique case (r_state)
      S_IDLE: begin
        if (bus.frame_tick) begin
          w_snap_nxt   = r_pending;
          w_idx_nxt    = 2'd0;
          w_tflag_nxt  = 1'b0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = S_QUERY;
          w_launch     = 1'b1;
          w_launch_idx = 2'd0;
          w_launch_dir = r_pending[0];
        end
      end

      S_QUERY: begin
        if (r_req) begin
          if (bus.query_ack) begin
            w_legal_nxt = bus.query_legal;
            w_req_nxt   = 1'b0;
            w_state_nxt = S_COMMIT;
          end else if (r_tmo_cnt == TMO_LAST) begin
            w_legal_nxt = 1'b0;
            w_tflag_nxt = 1'b1;
            w_req_nxt   = 1'b0;
            w_state_nxt = S_COMMIT;
          end else begin
            w_tmo_nxt = r_tmo_cnt + 8'd1;
          end
        end else begin
          w_legal_nxt = (w_cur_dir == 3'd0);
          w_state_nxt = S_COMMIT;
        end
      end

      S_COMMIT: begin
        if (r_legal) begin
          w_dirs_nxt[r_idx] = w_cur_dir;
        end
        if (r_idx == 2'd3) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_idx_nxt    = w_idx_inc;
          w_state_nxt  = S_QUERY;
          w_launch     = 1'b1;
          w_launch_idx = w_idx_inc;
          w_launch_dir = r_snap[w_idx_inc];
        end
      end

      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Request is raised on the edge that enters QUERY so an immediate ack costs no extra cycle.
    if (w_launch) begin
      w_tmo_nxt = 8'd0;
      if (needs_query(w_launch_dir)) begin
        w_req_nxt    = 1'b1;
        w_qghost_nxt = w_launch_idx;
        w_qdir_nxt   = w_launch_dir;
      end
    end
  end

  assign w_status_nxt = {1'b0, w_dirs_nxt[3], 1'b0, w_dirs_nxt[2],
                         1'b0, w_dirs_nxt[1], 1'b0, w_dirs_nxt[0]};

  assign bus.query_req        = r_req;
  assign bus.query_ghost      = r_qghost;
  assign bus.query_dir        = r_qdir;
  assign bus.ghost_dir_fpga   = r_dirs;
  assign bus.ghost_dir_status = r_status;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.timeout_flag     = r_tflag;
  assign bus.overrun_cnt      = r_ovr;

endmodule
